// File: rtl/osprey_axil_reg_slave.sv
// osprey_axil_reg_slave
//   AXI4-Lite responder holding NUM_REGS 32-bit control registers for the
//   ospreyUDP datapath. Registers are word-addressed from 0x0, and their
//   contents are exported on regs_out (reg k at [32k+31:32k]).
//   One transaction can be outstanding per channel. The AW and W handshakes
//   are accepted independently, in either order. All outputs are registered.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   S_AXI_AW*             write address channel (AWPROT ignored)
//   S_AXI_W*              write data channel with byte strobes
//   S_AXI_B*              write response channel (OKAY / SLVERR)
//   S_AXI_AR*             read address channel (ARPROT ignored)
//   S_AXI_R*              read data channel (OKAY / SLVERR)
//   regs_out              flat register contents
//   reg_wr_pulse          (only with OSPREY_AXIL_WR_PULSE_EN) one-cycle strobe
//                         per register, coincident with the BVALID rise of an
//                         OKAY commit to that register
//
// Build option: define OSPREY_AXIL_WR_PULSE_EN to add reg_wr_pulse.
module osprey_axil_reg_slave #(
    parameter int          NUM_REGS   = 4,
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] REG_RESET  = 32'h0
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]   regs_out
`ifdef OSPREY_AXIL_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
`endif
);

    localparam int         IDX_W  = ADDR_WIDTH - 2;
    localparam int         SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ---------------- write path ----------------
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           regs_q [NUM_REGS];
    logic [31:0]           regs_d [NUM_REGS];
    logic                  aw_hs, w_hs, commit, wr_in_range;
    logic [IDX_W-1:0]      wr_idx;
    logic [SEL_W-1:0]      wr_sel;

    assign wr_idx      = awaddr_q[ADDR_WIDTH-1:2];
    assign wr_sel      = awaddr_q[SEL_W+1:2];
    assign wr_in_range = (32'(wr_idx) < NUM_REGS);

    always_comb begin
        aw_hs     = S_AXI_AWVALID & awready_q;
        w_hs      = S_AXI_WVALID & wready_q;
        // Both halves were already held at the start of this cycle.
        commit    = aw_held_q & w_held_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_in_range ? OKAY : SLVERR;
        end else begin
            if (aw_hs) aw_held_d = 1'b1;
            if (w_hs)  w_held_d  = 1'b1;
            if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        end
        // READY is registered, so it is derived from next-state flags.
        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
            if (commit && wr_in_range && (wr_sel == SEL_W'(k))) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= REG_RESET;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
        end
    end

    // The held payload is only consumed while its flag is set, so it needs no reset.
    always_ff @(posedge ACLK) begin
        if (aw_hs) awaddr_q <= S_AXI_AWADDR;
        if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
    end

`ifdef OSPREY_AXIL_WR_PULSE_EN
    logic [NUM_REGS-1:0] wr_pulse_q;
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_pulse_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++)
                wr_pulse_q[k] <= commit && wr_in_range && (wr_sel == SEL_W'(k));
        end
    end
    assign reg_wr_pulse = wr_pulse_q;
`endif

    // ---------------- read path ----------------
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
    rd_state_t        rd_state_q;
    logic             arready_q, rvalid_q;
    logic [1:0]       rresp_q;
    logic [31:0]      rdata_q;
    logic [IDX_W-1:0] rd_idx;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_in_range;

    assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign rd_sel      = S_AXI_ARADDR[SEL_W+1:2];
    assign rd_in_range = (32'(rd_idx) < NUM_REGS);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (S_AXI_ARVALID && arready_q) begin
                        rd_state_q <= RD_RESP;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        // regs_q is the pre-commit value if a write lands on this edge.
                        rresp_q    <= rd_in_range ? OKAY : SLVERR;
                        rdata_q    <= rd_in_range ? regs_q[rd_sel] : 32'h0;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        rd_state_q <= RD_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[32*k +: 32] = regs_q[k];
    end

endmodule

// File: tb/tb_osprey_axil_reg_slave.sv
module tb_osprey_axil_reg_slave;

    localparam int NUM_REGS   = 4;
    localparam int ADDR_WIDTH = 6;

    logic                   ACLK = 1'b0;
    logic                   ARESET = 1'b1;
    logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR = '0;
    logic [2:0]             S_AXI_AWPROT = '0;
    logic                   S_AXI_AWVALID = 1'b0;
    logic                   S_AXI_AWREADY;
    logic [31:0]            S_AXI_WDATA = '0;
    logic [3:0]             S_AXI_WSTRB = '0;
    logic                   S_AXI_WVALID = 1'b0;
    logic                   S_AXI_WREADY;
    logic [1:0]             S_AXI_BRESP;
    logic                   S_AXI_BVALID;
    logic                   S_AXI_BREADY = 1'b0;
    logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR = '0;
    logic [2:0]             S_AXI_ARPROT = '0;
    logic                   S_AXI_ARVALID = 1'b0;
    logic                   S_AXI_ARREADY;
    logic [31:0]            S_AXI_RDATA;
    logic [1:0]             S_AXI_RRESP;
    logic                   S_AXI_RVALID;
    logic                   S_AXI_RREADY = 1'b0;
    logic [NUM_REGS*32-1:0] regs_out;
`ifdef OSPREY_AXIL_WR_PULSE_EN
    logic [NUM_REGS-1:0]    reg_wr_pulse;
`endif

    int n_cmp = 0;
    int n_err = 0;

    osprey_axil_reg_slave #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH), .REG_RESET(32'h0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .regs_out(regs_out)
`ifdef OSPREY_AXIL_WR_PULSE_EN
        , .reg_wr_pulse(reg_wr_pulse)
`endif
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_now, w_now;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
            w_now  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_now) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_now)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
            n++;
        end
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
        n_cmp++;
        if (S_AXI_BVALID !== 1'b1) begin
            n_err++;
            $display("FAIL write_timeout addr=%h: BVALID got %b want 1", addr, S_AXI_BVALID);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; resp = 2'bxx;
        end else begin
            resp = S_AXI_BRESP;
            S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin tick(); n++; end
        n_cmp++;
        if (S_AXI_RVALID !== 1'b1) begin
            n_err++;
            $display("FAIL read_timeout addr=%h: RVALID got %b want 1", addr, S_AXI_RVALID);
            data = 'x; resp = 2'bxx;
        end else begin
            data = S_AXI_RDATA; resp = S_AXI_RRESP;
            S_AXI_RREADY = 1'b1; tick(); S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (20) tick();
        n_cmp++; if (S_AXI_AWREADY !== 1'b0) begin n_err++; $display("FAIL rst_awready: got %b want 0", S_AXI_AWREADY); end
        n_cmp++; if (S_AXI_WREADY !== 1'b0) begin n_err++; $display("FAIL rst_wready: got %b want 0", S_AXI_WREADY); end
        n_cmp++; if (S_AXI_ARREADY !== 1'b0) begin n_err++; $display("FAIL rst_arready: got %b want 0", S_AXI_ARREADY); end
        n_cmp++; if (S_AXI_BVALID !== 1'b0) begin n_err++; $display("FAIL rst_bvalid: got %b want 0", S_AXI_BVALID); end
        n_cmp++; if (S_AXI_RVALID !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b want 0", S_AXI_RVALID); end
        n_cmp++; if (S_AXI_BRESP !== 2'b00) begin n_err++; $display("FAIL rst_bresp: got %b want 00", S_AXI_BRESP); end
        n_cmp++; if (S_AXI_RRESP !== 2'b00) begin n_err++; $display("FAIL rst_rresp: got %b want 00", S_AXI_RRESP); end
        n_cmp++; if (S_AXI_RDATA !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", S_AXI_RDATA); end
        n_cmp++; if (regs_out !== 128'h0) begin n_err++; $display("FAIL rst_regs: got %h want 0", regs_out); end
        ARESET = 1'b0;
        tick();
        n_cmp++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            n_err++; $display("FAIL rst_release_readys: got %b want 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    endtask

    task automatic test_basic_rw();
        logic [1:0]  resp;
        logic [31:0] data;
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(4 * i), 32'(i + 1), 4'hF, resp);
            n_cmp++; if (resp !== 2'b00) begin n_err++; $display("FAIL basic_bresp[%0d]: got %b want 00", i, resp); end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(4 * i), data, resp);
            n_cmp++; if (data !== 32'(i + 1)) begin n_err++; $display("FAIL basic_rdata[%0d]: got %h want %h", i, data, 32'(i + 1)); end
            n_cmp++; if (resp !== 2'b00) begin n_err++; $display("FAIL basic_rresp[%0d]: got %b want 00", i, resp); end
        end
        n_cmp++; if (regs_out !== 128'h00000004_00000003_00000002_00000001) begin
            n_err++; $display("FAIL basic_regs_out: got %h want 00000004000000030000000200000001", regs_out); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0]  resp;
        logic [31:0] data;
        S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        n_cmp++; if (S_AXI_WREADY !== 1'b0) begin n_err++; $display("FAIL wfirst_wready_drop: got %b want 0", S_AXI_WREADY); end
        tick(); tick();
        S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
        n_cmp++; if (S_AXI_WREADY !== 1'b0) begin n_err++; $display("FAIL wfirst_wready_held: got %b want 0", S_AXI_WREADY); end
        n_cmp++; if (S_AXI_AWREADY !== 1'b1) begin n_err++; $display("FAIL wfirst_awready: got %b want 1", S_AXI_AWREADY); end
        tick();
        S_AXI_AWVALID = 1'b0;
        n_cmp++; if (S_AXI_BVALID !== 1'b0) begin n_err++; $display("FAIL wfirst_bvalid_early: got %b want 0", S_AXI_BVALID); end
        tick();
        n_cmp++; if (S_AXI_BVALID !== 1'b1) begin n_err++; $display("FAIL wfirst_bvalid: got %b want 1", S_AXI_BVALID); end
        n_cmp++; if (S_AXI_BRESP !== 2'b00) begin n_err++; $display("FAIL wfirst_bresp: got %b want 00", S_AXI_BRESP); end
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
        axi_read(6'h08, data, resp);
        n_cmp++; if (data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wfirst_rdata: got %h want a5a5a5a5", data); end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [31:0] data;
        axi_write(6'h04, 32'hFFFFFFFF, 4'b0010, resp);
        n_cmp++; if (resp !== 2'b00) begin n_err++; $display("FAIL strb_bresp: got %b want 00", resp); end
        axi_read(6'h04, data, resp);
        n_cmp++; if (data !== 32'h0000FF02) begin n_err++; $display("FAIL strb_rdata: got %h want 0000ff02", data); end
    endtask

    task automatic test_slverr();
        logic [1:0]  resp;
        logic [31:0] data;
        axi_write(6'h10, 32'hDEADBEEF, 4'hF, resp);
        n_cmp++; if (resp !== 2'b10) begin n_err++; $display("FAIL slverr_bresp: got %b want 10", resp); end
        n_cmp++; if (regs_out !== 128'h00000004_A5A5A5A5_0000FF02_00000001) begin
            n_err++; $display("FAIL slverr_regs: got %h want 00000004a5a5a5a50000ff0200000001", regs_out); end
        axi_read(6'h3C, data, resp);
        n_cmp++; if (resp !== 2'b10) begin n_err++; $display("FAIL slverr_rresp: got %b want 10", resp); end
        n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL slverr_rdata: got %h want 0", data); end
    endtask

    task automatic test_read_during_commit();
        logic [1:0]  resp;
        logic [31:0] data;
        S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h55555555; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        n_cmp++; if (S_AXI_RVALID !== 1'b1) begin n_err++; $display("FAIL rdc_rvalid: got %b want 1", S_AXI_RVALID); end
        n_cmp++; if (S_AXI_RDATA !== 32'hA5A5A5A5) begin n_err++; $display("FAIL rdc_rdata_old: got %h want a5a5a5a5", S_AXI_RDATA); end
        n_cmp++; if (S_AXI_BVALID !== 1'b1) begin n_err++; $display("FAIL rdc_bvalid: got %b want 1", S_AXI_BVALID); end
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        n_cmp++; if ({S_AXI_RVALID, S_AXI_BVALID} !== 2'b00) begin
            n_err++; $display("FAIL rdc_valids_clear: got %b want 00", {S_AXI_RVALID, S_AXI_BVALID}); end
        n_cmp++; if ({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b111) begin
            n_err++; $display("FAIL rdc_readys_back: got %b want 111", {S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY}); end
        axi_read(6'h08, data, resp);
        n_cmp++; if (data !== 32'h55555555) begin n_err++; $display("FAIL rdc_rdata_new: got %h want 55555555", data); end
    endtask

    task automatic test_back_to_back();
        // Write reg0 and read reg3 together, then hold BREADY/RREADY low.
        S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h00000011; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 6'h0C; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        tick(); tick();
        // Second write is offered while the first response is still pending.
        S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h00000022; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin
                n_err++; $display("FAIL bp_valids[%0d]: got %b want 11", i, {S_AXI_BVALID, S_AXI_RVALID}); end
            n_cmp++; if (S_AXI_BRESP !== 2'b00 || S_AXI_RRESP !== 2'b00) begin
                n_err++; $display("FAIL bp_resps[%0d]: got %b/%b want 00/00", i, S_AXI_BRESP, S_AXI_RRESP); end
            n_cmp++; if (S_AXI_RDATA !== 32'h4) begin n_err++; $display("FAIL bp_rdata[%0d]: got %h want 4", i, S_AXI_RDATA); end
            n_cmp++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
                n_err++; $display("FAIL bp_readys[%0d]: got %b want 000", i, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
            tick();
        end
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
        n_cmp++; if (S_AXI_BVALID !== 1'b0) begin n_err++; $display("FAIL bp_bvalid_clear: got %b want 0", S_AXI_BVALID); end
        n_cmp++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin
            n_err++; $display("FAIL bp_wr_readys_back: got %b want 11", {S_AXI_AWREADY, S_AXI_WREADY}); end
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n_cmp++; if (S_AXI_AWREADY !== 1'b0) begin n_err++; $display("FAIL bp_second_aw_taken: got %b want 0", S_AXI_AWREADY); end
        tick(); tick();
        n_cmp++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin
            n_err++; $display("FAIL bp_second_valids: got %b want 11", {S_AXI_BVALID, S_AXI_RVALID}); end
        n_cmp++; if (regs_out[63:0] !== 64'h00000022_00000011) begin
            n_err++; $display("FAIL bp_regs: got %h want 0000002200000011", regs_out[63:0]); end
    endtask

    task automatic test_reset_mid();
        // Entered with BVALID and RVALID both pending.
        ARESET = 1'b1;
        tick();
        n_cmp++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin
            n_err++; $display("FAIL mid_valids: got %b want 00", {S_AXI_BVALID, S_AXI_RVALID}); end
        n_cmp++; if (regs_out !== 128'h0) begin n_err++; $display("FAIL mid_regs: got %h want 0", regs_out); end
        n_cmp++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            n_err++; $display("FAIL mid_readys_low: got %b want 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
        ARESET = 1'b0;
        tick();
        n_cmp++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            n_err++; $display("FAIL mid_readys_back: got %b want 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
        n_cmp++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin
            n_err++; $display("FAIL mid_valids_after: got %b want 00", {S_AXI_BVALID, S_AXI_RVALID}); end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_w_before_aw();
        test_strobe();
        test_slverr();
        test_read_during_commit();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
